// File: rtl/lcd_controller_if.sv
// lcd_controller_if: Avalon-MM slave bus carrying single-byte writes and status reads to the LCD controller.
interface lcd_controller_if;
  logic       address;
  logic       chipselect;
  logic       byteenable;
  logic       read;
  logic       write;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       waitrequest;
  logic [1:0] response;
  modport master (
    output address, chipselect, byteenable, read, write, writedata,
    input  readdata, waitrequest, response
  );
  modport slave (
    input  address, chipselect, byteenable, read, write, writedata,
    output readdata, waitrequest, response
  );
endinterface

// File: rtl/lcd_controller.sv
// lcd_controller: turns Avalon byte writes into timed HD44780 bus cycles and runs the power-up init itself.
module lcd_controller #(
  parameter int POWERUP_CYCLES     = 750000,
  parameter int SETUP_CYCLES       = 3,
  parameter int EN_PULSE_CYCLES    = 12,
  parameter int HOLD_CYCLES        = 2,
  parameter int CMD_DELAY_CYCLES   = 2000,
  parameter int CLEAR_DELAY_CYCLES = 82000
) (
  input  logic             clk,
  input  logic             reset,
  lcd_controller_if.slave  bus,
  output logic [7:0]       lcd_data_o,
  output logic             lcd_rs_o,
  output logic             lcd_rw_o,
  output logic             lcd_en_o,
  output logic             lcd_on_o,
  output logic             lcd_blon_o
);
  localparam int M1   = POWERUP_CYCLES > CLEAR_DELAY_CYCLES ? POWERUP_CYCLES : CLEAR_DELAY_CYCLES;
  localparam int M2   = M1 > CMD_DELAY_CYCLES ? M1 : CMD_DELAY_CYCLES;
  localparam int M3   = M2 > EN_PULSE_CYCLES ? M2 : EN_PULSE_CYCLES;
  localparam int M4   = M3 > SETUP_CYCLES ? M3 : SETUP_CYCLES;
  localparam int MAXD = M4 > HOLD_CYCLES ? M4 : HOLD_CYCLES;
  localparam int CW   = $clog2(MAXD + 1);
  typedef enum logic [2:0] {POWERUP, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, DELAY} state_e;
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            init_q, init_d, rs_q, rs_d, en_q;
  logic [7:0]      data_q, data_d, rom;
  logic            accept, done, long_wait;
  assign accept          = state_q == IDLE && bus.chipselect && bus.write;
  assign bus.waitrequest = !(bus.chipselect && (bus.write ? state_q == IDLE : bus.read));
  assign bus.readdata    = {bus.chipselect && state_q != IDLE, 7'b0};
  assign bus.response    = 2'b00;
  assign rom       = idx_q == 2'd0 ? 8'h38 : idx_q == 2'd1 ? 8'h0C : idx_q == 2'd2 ? 8'h06 : 8'h01;
  assign done      = cnt_q == '0;
  // clear (0x01) and return-home (0x02/0x03) need the long execution time
  assign long_wait = !rs_q && data_q[7:2] == 6'b0 && data_q != 8'h00;
  assign lcd_data_o = data_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_en_o   = en_q;
  assign lcd_rw_o   = 1'b0;
  assign lcd_on_o   = 1'b1;
  assign lcd_blon_o = 1'b1;
  always_comb begin
    state_d = state_q;
    cnt_d   = done ? cnt_q : cnt_q - CW'(1);
    idx_d   = idx_q;
    init_d  = init_q;
    data_d  = data_q;
    rs_d    = rs_q;
    case (state_q)
      // counter starts at 0 out of reset, so power-up counts upwards
      POWERUP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(POWERUP_CYCLES - 1)) begin
          state_d = INIT_LOAD;
          cnt_d   = '0;
        end
      end
      INIT_LOAD: begin
        state_d = SETUP;
        cnt_d   = CW'(SETUP_CYCLES - 1);
        data_d  = rom;
        rs_d    = 1'b0;
      end
      IDLE: if (accept && bus.byteenable) begin
        state_d = SETUP;
        cnt_d   = CW'(SETUP_CYCLES - 1);
        data_d  = bus.writedata;
        rs_d    = bus.address;
      end
      SETUP: if (done) begin
        state_d = PULSE;
        cnt_d   = CW'(EN_PULSE_CYCLES - 1);
      end
      PULSE: if (done) begin
        state_d = HOLD;
        cnt_d   = CW'(HOLD_CYCLES - 1);
      end
      HOLD: if (done) begin
        state_d = DELAY;
        cnt_d   = long_wait ? CW'(CLEAR_DELAY_CYCLES - 1) : CW'(CMD_DELAY_CYCLES - 1);
      end
      DELAY: if (done) begin
        if (init_q && idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          state_d = INIT_LOAD;
          cnt_d   = '0;
        end else begin
          init_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = POWERUP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= POWERUP;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      init_q  <= 1'b1;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      init_q  <= init_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= state_d == PULSE;
    end
  end
endmodule
